alu_arbiter_ctrl: RTL and testbench

ALU_ARBITER_CTRL -- requirements
Module: alu_arbiter_ctrl

---
 rtl/alu_arbiter_ctrl.sv | 130 +++++++++++++
 tb/tb_alu_arbiter_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_ctrl.sv
// Two-requester round-robin front end for a shared tri-state ALU.
// One operation in flight; divide-by-zero is answered locally without touching the ALU.
module alu_arbiter_ctrl #(
  parameter logic [15:0] DIV_ERR_VAL = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [3:0]  req0_cmd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [3:0]  req1_cmd,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_cmd,
  output logic        alu_oe,
  input  logic [15:0] alu_d,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester transfers when valid & ready are both high at a rising
  // clock edge; the response transfers when rsp_valid & rsp_ready are both high.

  localparam logic [3:0] CMD_DIV = 4'b0101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last_id;
  logic        r_id;
  logic        r_err;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [3:0]  r_cmd;
  logic [15:0] r_data;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_acc;
  logic        w_acc_id;
  logic [7:0]  w_a;
  logic [7:0]  w_b;
  logic [3:0]  w_cmd;
  logic        w_div0;

  // Contention goes to whoever was not granted last.
  assign w_gnt0 = req0_valid & (~req1_valid | r_last_id);
  assign w_gnt1 = req1_valid & (~req0_valid | ~r_last_id);

  assign req0_ready = (r_state == S_IDLE) & ~rst & w_gnt0;
  assign req1_ready = (r_state == S_IDLE) & ~rst & w_gnt1;

  assign w_acc    = req0_ready | req1_ready;
  assign w_acc_id = req1_ready;
  assign w_a      = w_acc_id ? req1_a   : req0_a;
  assign w_b      = w_acc_id ? req1_b   : req0_b;
  assign w_cmd    = w_acc_id ? req1_cmd : req0_cmd;
  assign w_div0   = (w_cmd == CMD_DIV) && (w_b == 8'd0);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_acc) w_next = w_div0 ? S_RESP : S_EXEC;
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_last_id <= 1'b1;
      r_id      <= 1'b0;
      r_err     <= 1'b0;
      r_a       <= 8'd0;
      r_b       <= 8'd0;
      r_cmd     <= 4'd0;
      r_data    <= 16'd0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_a       <= w_a;
        r_b       <= w_b;
        r_cmd     <= w_cmd;
        r_id      <= w_acc_id;
        r_last_id <= w_acc_id;
        if (w_div0) begin
          r_data <= DIV_ERR_VAL;
          r_err  <= 1'b1;
        end
      end
      // The ALU drives alu_d only while alu_oe is high, i.e. during EXEC.
      if (r_state == S_EXEC) begin
        r_data <= alu_d;
        r_err  <= 1'b0;
      end
    end
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_cmd   = r_cmd;
  assign alu_oe    = (r_state == S_EXEC);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
  assign rsp_err   = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Bench for alu_arbiter_ctrl: directed scenarios followed by random transactions,
// predicted by a transaction-level round-robin/ALU model and checked through a queue.
module tb_alu_arbiter_ctrl;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, MUL = 4'd2, DIV = 4'd5, BUFF = 4'd15;

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [7:0]  req0_a, req0_b;
  logic [3:0]  req0_cmd;
  logic        req1_valid, req1_ready;
  logic [7:0]  req1_a, req1_b;
  logic [3:0]  req1_cmd;
  logic [7:0]  alu_a, alu_b;
  logic [3:0]  alu_cmd;
  logic        alu_oe;
  logic [15:0] alu_d;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [15:0] rsp_data;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  bit m_last;                 // model: requester granted most recently
  logic [17:0] exp_q[$];      // {id, err, data}

  alu_arbiter_ctrl #(.DIV_ERR_VAL(16'hFFFF)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cmd(req1_cmd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd), .alu_oe(alu_oe), .alu_d(alu_d),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shared ALU
  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] c);
    case (c)
      ADD:     alu_fn = {8'd0, a} + {8'd0, b};
      SUB:     alu_fn = (a > b) ? {8'd0, a - b} : {8'd0, b - a};
      MUL:     alu_fn = {8'd0, a} * {8'd0, b};
      DIV:     alu_fn = (b == 8'd0) ? 16'h0BAD : {8'd0, a / b};
      BUFF:    alu_fn = {8'd0, a};
      default: alu_fn = {a, b} ^ 16'h5A5A;
    endcase
  endfunction

  always_comb alu_d = alu_oe ? alu_fn(alu_a, alu_b, alu_cmd) : 16'hzzzz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: present one request pattern from IDLE (called at posedge+1) and follow
  // the resulting transaction to completion, leaving the bench at posedge+1 in IDLE.
  task automatic do_txn(input bit v0, input bit v1,
                        input logic [7:0] a0, input logic [7:0] b0, input logic [3:0] c0,
                        input logic [7:0] a1, input logic [7:0] b1, input logic [3:0] c1,
                        input int hold, input bit bv0, input bit bv1);
    bit w, div0;
    logic [7:0] wa, wb;
    logic [3:0] wc;
    logic [15:0] ed, held;
    logic [17:0] e;
    int cyc, oe_cnt, lat;
    w  = (v0 && v1) ? ~m_last : v1;
    wa = w ? a1 : a0;
    wb = w ? b1 : b0;
    wc = w ? c1 : c0;
    div0 = (wc == DIV) && (wb == 8'd0);
    ed = div0 ? 16'hFFFF : alu_fn(wa, wb, wc);
    exp_q.push_back({w, div0, ed});
    m_last = w;
    lat = div0 ? 1 : 2;

    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cmd = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cmd = c1;
    #1;
    check("req0_ready_grant", req0_ready, !w);
    check("req1_ready_grant", req1_ready, w);
    @(posedge clk); #1;
    req0_valid = bv0; req1_valid = bv1;
    req0_a = 8'($urandom); req1_a = 8'($urandom);
    req0_b = 8'($urandom); req1_b = 8'($urandom);
    req0_cmd = 4'($urandom); req1_cmd = 4'($urandom);
    #1;
    cyc = 1; oe_cnt = 0;
    forever begin
      check("busy_ready", {req0_ready, req1_ready}, 2'b00);
      if (alu_oe === 1'b1) begin
        oe_cnt++;
        check("alu_ops", {alu_a, alu_b, alu_cmd}, {wa, wb, wc});
      end
      if (rsp_valid === 1'b1 || cyc >= 6) break;
      @(posedge clk); #2;
      cyc++;
    end
    check("rsp_latency", cyc, lat);
    check("alu_oe_cycles", oe_cnt, div0 ? 0 : 1);
    e = exp_q.pop_front();
    check("rsp_id", rsp_id, e[17]);
    check("rsp_err", rsp_err, e[16]);
    check("rsp_data", rsp_data, e[15:0]);
    held = rsp_data;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #2;
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_data", rsp_data, held);
      check("hold_ready", {req0_ready, req1_ready}, 2'b00);
    end
    rsp_ready = 1'b1;
    #1;
    check("resp_ready_block", {req0_ready, req1_ready}, 2'b00);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("back_to_idle", rsp_valid, 1'b0);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_no_oe", alu_oe, 1'b0);
      check("idle_no_rsp", rsp_valid, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'd1; req0_b = 8'd2; req0_cmd = ADD;
    req1_valid = 1'b1; req1_a = 8'd3; req1_b = 8'd4; req1_cmd = ADD;
    m_last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {req0_ready, req1_ready}, 2'b00);
    check("rst_oe_valid", {alu_oe, rsp_valid}, 2'b00);
    check("rst_rsp", {rsp_id, rsp_err, rsp_data}, 18'd0);
    check("rst_alu", {alu_a, alu_b, alu_cmd}, 20'd0);
    rst = 1'b0; rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    // Contention from reset: req0, then req1, then req0 again
    do_txn(1, 1, 8'd15, 8'd17, MUL, 8'd3, 8'd10, SUB, 0, 1, 1);
    do_txn(1, 1, 8'd15, 8'd17, MUL, 8'd3, 8'd10, SUB, 0, 0, 0);
    do_txn(1, 1, 8'd15, 8'd17, MUL, 8'd3, 8'd10, SUB, 0, 0, 0);
    // Single ADD, immediate rsp_ready
    do_txn(1, 0, 8'd20, 8'd22, ADD, 8'd0, 8'd0, ADD, 0, 0, 0);
    // Divide by zero from requester 1
    do_txn(0, 1, 8'd0, 8'd0, ADD, 8'd100, 8'd0, DIV, 0, 0, 0);
    // Back-pressure for 5 cycles with both requesters waiting
    do_txn(1, 1, 8'd200, 8'd100, ADD, 8'd9, 8'd9, MUL, 5, 1, 1);

    // Reset during EXEC
    req1_valid = 1'b1; req1_a = 8'd5; req1_b = 8'd6; req1_cmd = ADD;
    @(posedge clk); #1;
    check("pre_rst_exec", alu_oe, 1'b1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_rst_oe_valid", {alu_oe, rsp_valid}, 2'b00);
    check("async_rst_ready", {req0_ready, req1_ready}, 2'b00);
    check("async_rst_alu", {alu_a, alu_b, alu_cmd}, 20'd0);
    check("async_rst_rsp", {rsp_id, rsp_err, rsp_data}, 18'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    m_last = 1'b1;
    idle_check(3);
    do_txn(1, 1, 8'd7, 8'd8, ADD, 8'd1, 8'd1, SUB, 0, 0, 0);

    // req0 shows up while req1 is busy and withdraws before it can be granted
    do_txn(0, 1, 8'd0, 8'd0, ADD, 8'd12, 8'd4, DIV, 2, 1, 0);
    idle_check(3);

    // Random transactions
    for (int n = 0; n < 40; n++) begin
      int pat;
      logic [7:0] ra0, rb0, ra1, rb1;
      logic [3:0] rc0, rc1;
      pat = $urandom_range(1, 3);
      ra0 = 8'($urandom); rb0 = 8'($urandom); rc0 = 4'($urandom_range(0, 15));
      ra1 = 8'($urandom); rb1 = 8'($urandom); rc1 = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin rc0 = DIV; rb0 = 8'd0; end
      if ($urandom_range(0, 3) == 0) begin rc1 = DIV; rb1 = 8'd0; end
      do_txn(pat[0], pat[1], ra0, rb0, rc0, ra1, rb1, rc1,
             $urandom_range(0, 3), 1'($urandom), 1'($urandom));
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
